mem_bus_arbiter: RTL and testbench

- Shares one single-port memory bus between the core's instruction-fetch requester and its load/store requester.
- Splits off memory-mapped IO accesses (addresses at or above IO_BASE) to the IO register block, so they never reach memory.
- Sequences each access with a request/ack handshake and a timeout, and drives the core stall.
- Sits between the rv32 core and the memory/IO-register blocks.

---
 rtl/mem_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one memory port between fetch and load/store,
// routes MMIO accesses to the IO block, and handles ack timeouts and stall.
module mem_bus_arbiter #(
  parameter logic [31:0] IO_BASE  = 32'hFFFF_FFF0,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  output logic [31:0] fetch_instr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        io_read,
  output logic        io_write,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  output logic        cpu_stall
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    MEM_D,
    MEM_F,
    IO_ACC,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic          last_f_q, last_f_d;
  logic          own_f_q, own_f_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   instr_q, instr_d;

  logic d_req;
  logic mmio;
  logic in_mem;

  assign d_req  = d_read | d_write;
  assign mmio   = (d_addr >= IO_BASE);
  assign in_mem = (state_q == MEM_D) || (state_q == MEM_F);

  // Next-state, grant and capture logic for one bus transaction
  always_comb begin
    state_d  = state_q;
    last_f_d = last_f_q;
    own_f_d  = own_f_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    instr_d  = instr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (d_req && mmio) begin
          state_d = IO_ACC;
          own_f_d = 1'b0;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wr_d    = d_write;
        end else if (d_req && (!fetch_req || last_f_q)) begin
          state_d = MEM_D;
          own_f_d = 1'b0;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wr_d    = d_write;
        end else if (fetch_req) begin
          state_d = MEM_F;
          own_f_d = 1'b1;
          addr_d  = fetch_addr;
          wdata_d = '0;
          wr_d    = 1'b0;
        end
      end
      MEM_D, MEM_F: begin
        if (mem_ack) begin
          state_d = DONE;
          if (own_f_q) instr_d = mem_rdata;
          else if (!wr_q) rdata_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (own_f_q) instr_d = ERR_DATA;
          else if (!wr_q) rdata_d = ERR_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IO_ACC: begin
        state_d = DONE;
        if (!wr_q) rdata_d = io_rdata;
      end
      DONE: begin
        state_d  = IDLE;
        last_f_d = own_f_q;
        cnt_d    = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-transaction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_f_q <= 1'b0;
      own_f_q  <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      last_f_q <= last_f_d;
      own_f_q  <= own_f_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      instr_q  <= instr_d;
    end
  end

  assign mem_read    = in_mem & ~wr_q;
  assign mem_write   = (state_q == MEM_D) & wr_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign io_read     = (state_q == IO_ACC) & ~wr_q;
  assign io_write    = (state_q == IO_ACC) & wr_q;
  assign io_addr     = addr_q;
  assign io_wdata    = wdata_q;
  assign fetch_ack   = (state_q == DONE) & own_f_q;
  assign d_ack       = (state_q == DONE) & ~own_f_q;
  assign d_err       = (state_q == DONE) & err_q;
  assign d_rdata     = rdata_q;
  assign fetch_instr = instr_q;
  // Reset forces stall low so the core is not frozen while held in reset
  assign cpu_stall   = rst & (fetch_req | d_req) & ~(fetch_ack | d_ack);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter.
// Each task drives one scenario and checks against hand-computed values.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack;
  logic [31:0] fetch_instr;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        io_read;
  logic        io_write;
  logic [31:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        cpu_stall;

  int vectors = 0;
  int miscompares = 0;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .fetch_instr(fetch_instr),
    .d_read(d_read), .d_write(d_write),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .io_read(io_read), .io_write(io_write),
    .io_addr(io_addr), .io_wdata(io_wdata),
    .io_rdata(io_rdata), .cpu_stall(cpu_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    fetch_req = 1'b1; fetch_addr = 32'h0;
    d_read = 1'b0; d_write = 1'b0;
    d_addr = 32'h0; d_wdata = 32'h0;
    mem_rdata = 32'h0; mem_ack = 1'b0;
    io_rdata = 32'h0;
    tick();
    vectors++;
    if ({fetch_ack, d_ack, d_err, mem_read, mem_write,
         io_read, io_write, cpu_stall} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 00000000",
        {fetch_ack, d_ack, d_err, mem_read, mem_write,
         io_read, io_write, cpu_stall});
    end
    vectors++;
    if ({fetch_instr, d_rdata, mem_addr, io_wdata} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 0",
        {fetch_instr, d_rdata, mem_addr, io_wdata});
    end
    fetch_req = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int n;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_read && mem_addr == 32'h100 && cpu_stall) n++;
      if (i == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
      end
    end
    vectors++;
    if (n !== 3) begin
      miscompares++;
      $display("FAIL fetch_rd_cycles got %0d want 3", n);
    end
    tick();
    mem_ack = 1'b0;
    vectors++;
    if ({fetch_ack, d_ack, mem_read, cpu_stall, d_err} !== 5'b10000) begin
      miscompares++;
      $display("FAIL fetch_ack got %b want 10000",
        {fetch_ack, d_ack, mem_read, cpu_stall, d_err});
    end
    vectors++;
    if (fetch_instr !== 32'h0050_0093) begin
      miscompares++;
      $display("FAIL fetch_instr got %h want 00500093", fetch_instr);
    end
    fetch_req = 1'b0;
    tick();
    vectors++;
    if ({fetch_ack, mem_read} !== 2'b00) begin
      miscompares++;
      $display("FAIL fetch_idle got %b want 00", {fetch_ack, mem_read});
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr [4];
    logic [31:0] rdv [4];
    exp_addr[0] = 32'h300; exp_addr[1] = 32'h200;
    exp_addr[2] = 32'h304; exp_addr[3] = 32'h204;
    rdv[0] = 32'h11; rdv[1] = 32'h22;
    rdv[2] = 32'h33; rdv[3] = 32'h44;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'h300;
    d_read = 1'b1; d_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k > 0) tick();
      vectors++;
      if ({mem_read, mem_addr} !== {1'b1, exp_addr[k]}) begin
        miscompares++;
        $display("FAIL rr_grant%0d got %b/%h want 1/%h",
          k, mem_read, mem_addr, exp_addr[k]);
      end
      mem_ack = 1'b1; mem_rdata = rdv[k];
      tick();
      mem_ack = 1'b0;
      vectors++;
      if ({fetch_ack, d_ack} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL rr_ack%0d got %b", k, {fetch_ack, d_ack});
      end
      if (k == 0) fetch_addr = 32'h304;
      if (k == 1) d_addr = 32'h204;
    end
    vectors++;
    if ({fetch_instr, d_rdata} !== {32'h33, 32'h44}) begin
      miscompares++;
      $display("FAIL rr_data got %h/%h want 33/44", fetch_instr, d_rdata);
    end
    fetch_req = 1'b0; d_read = 1'b0;
    tick();
  endtask

  task automatic test_mmio_write();
    int wr_cycles;
    int mw;
    d_write = 1'b1; d_addr = 32'hFFFF_FFFF; d_wdata = 32'hA5;
    wr_cycles = 0; mw = 0;
    tick();
    if (io_write && io_wdata == 32'hA5 && io_addr == 32'hFFFF_FFFF)
      wr_cycles++;
    if (mem_write) mw++;
    vectors++;
    if (d_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL mmio_w_early_ack got %b want 0", d_ack);
    end
    tick();
    if (io_write) wr_cycles++;
    if (mem_write) mw++;
    vectors++;
    if ({d_ack, d_err, cpu_stall} !== 3'b100) begin
      miscompares++;
      $display("FAIL mmio_w_ack got %b want 100", {d_ack, d_err, cpu_stall});
    end
    d_write = 1'b0;
    tick();
    if (io_write) wr_cycles++;
    if (mem_write) mw++;
    vectors++;
    if ({wr_cycles, mw} !== {32'd1, 32'd0}) begin
      miscompares++;
      $display("FAIL mmio_w_strobes got io=%0d mem=%0d want 1/0",
        wr_cycles, mw);
    end
    vectors++;
    if (d_rdata !== 32'h44) begin
      miscompares++;
      $display("FAIL mmio_w_rdata_hold got %h want 44", d_rdata);
    end
  endtask

  task automatic test_mmio_read_vs_fetch();
    d_read = 1'b1; d_addr = 32'hFFFF_FFFC; io_rdata = 32'h3C;
    fetch_req = 1'b1; fetch_addr = 32'h400;
    tick();
    vectors++;
    if ({io_read, mem_read, io_addr} !== {2'b10, 32'hFFFF_FFFC}) begin
      miscompares++;
      $display("FAIL mmio_r_first got %b%b/%h want 10/fffffffc",
        io_read, mem_read, io_addr);
    end
    tick();
    vectors++;
    if ({d_ack, fetch_ack, d_rdata} !== {2'b10, 32'h3C}) begin
      miscompares++;
      $display("FAIL mmio_r_ack got %b%b/%h want 10/3c",
        d_ack, fetch_ack, d_rdata);
    end
    d_read = 1'b0; io_rdata = 32'h0;
    tick();
    tick();
    vectors++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h400}) begin
      miscompares++;
      $display("FAIL mmio_r_fetch_after got %b/%h want 1/400",
        mem_read, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h55;
    tick();
    mem_ack = 1'b0;
    vectors++;
    if ({fetch_ack, fetch_instr} !== {1'b1, 32'h55}) begin
      miscompares++;
      $display("FAIL mmio_r_fetch_ack got %b/%h want 1/55",
        fetch_ack, fetch_instr);
    end
    fetch_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int n;
    bit got;
    for (int pass = 0; pass < 2; pass++) begin
      d_read = 1'b1; d_addr = 32'h40;
      mem_rdata = 32'h77;
      n = 0; got = 1'b0;
      tick();
      for (int i = 0; i < 40; i++) begin
        if (d_ack) begin
          got = 1'b1;
          break;
        end
        if (mem_read) begin
          n++;
          if (pass == 1 && n == 16) mem_ack = 1'b1;
        end
        tick();
        mem_ack = 1'b0;
      end
      vectors++;
      if (!got || n !== 16) begin
        miscompares++;
        $display("FAIL timeout%0d_cycles got %0d (ack=%b) want 16",
          pass, n, got);
      end
      vectors++;
      if ({d_err, d_rdata} !== ((pass == 0) ? {1'b1, 32'hDEAD_BEEF}
                                            : {1'b0, 32'h77})) begin
        miscompares++;
        $display("FAIL timeout%0d_result got err=%b data=%h",
          pass, d_err, d_rdata);
      end
      d_read = 1'b0;
      tick();
      vectors++;
      if ({d_ack, d_err, mem_read} !== 3'b000) begin
        miscompares++;
        $display("FAIL timeout%0d_after got %b want 000",
          pass, {d_ack, d_err, mem_read});
      end
    end
  endtask

  task automatic test_reset_mid();
    d_read = 1'b1; d_addr = 32'h80;
    tick();
    tick();
    vectors++;
    if (mem_read !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre got %b want 1", mem_read);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({mem_read, cpu_stall, d_ack, fetch_ack, mem_addr}
        !== {4'b0000, 32'h0}) begin
      miscompares++;
      $display("FAIL rstmid_async got %b/%h want 0000/0",
        {mem_read, cpu_stall, d_ack, fetch_ack}, mem_addr);
    end
    d_read = 1'b0;
    tick();
    rst = 1'b1;
    fetch_req = 1'b1; fetch_addr = 32'h500;
    tick();
    vectors++;
    if ({mem_read, mem_addr} !== {1'b1, 32'h500}) begin
      miscompares++;
      $display("FAIL rstmid_regrant got %b/%h want 1/500",
        mem_read, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    tick();
    mem_ack = 1'b0;
    vectors++;
    if ({fetch_ack, d_ack, fetch_instr, d_rdata}
        !== {2'b10, 32'h1234, 32'h0}) begin
      miscompares++;
      $display("FAIL rstmid_fetch got %b%b/%h/%h want 10/1234/0",
        fetch_ack, d_ack, fetch_instr, d_rdata);
    end
    fetch_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_round_robin();
    test_mmio_write();
    test_mmio_read_vs_fetch();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
      vectors, miscompares);
    $finish;
  end

endmodule
